// File: rtl/program_loader_pkg.sv
// Shared constants and state encodings for the serial program loader.
package program_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        F_IDLE,
        F_LEN0,
        F_LEN1,
        F_DATA,
        F_CSUM
    } frame_state_t;

endpackage

// File: rtl/program_loader_uart_rx.sv
// 8N1 UART byte receiver: input synchronizer, baud counter and byte FSM.
module uart_rx_byte
    import program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_TICK = CW'(CLKS_PER_BIT / 2 - 1);

    logic            sync1_q, sync2_q, prev_q;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d, err_q, err_d;
    logic            bit_end;

    assign bit_end = (cnt_q == LAST_TICK);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= R_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        shift_q <= shift_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            R_IDLE:  if (prev_q && !sync2_q) state_d = R_START;
            R_START: if (cnt_q == HALF_TICK) state_d = sync2_q ? R_IDLE : R_DATA;
            R_DATA:  if (bit_end && bit_q == 3'd7) state_d = R_STOP;
            R_STOP:  if (bit_end) state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
        if (!en_i) state_d = R_IDLE;
    end

    // Counter restarts on every state change, so data bits are sampled a whole bit after mid-start.
    always_comb begin
        bit_d   = bit_q;
        shift_d = shift_q;
        if (state_q == R_IDLE || state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == R_DATA && bit_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_q == R_IDLE) bit_d = '0;
        if (state_q == R_DATA && bit_end) begin
            shift_d = {sync2_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
        end
    end

    always_comb begin
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (en_i && state_q == R_STOP && bit_end) begin
            valid_d = sync2_q;
            err_d   = !sync2_q;
        end
    end

    assign byte_valid_o = valid_q;
    assign frame_err_o  = err_q;
    assign byte_data_o  = shift_q;

endmodule

// File: rtl/program_loader.sv
// Frame decoder and memory write port: SYNC, LEN, LEN*4 data bytes, XOR checksum.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int         CLK_HZ     = 50000000,
    parameter int         BAUD       = 115200,
    parameter int         ADDR_WIDTH = 16,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                  physical_clock,
    input  logic                  reset,
    input  logic                  load_enable,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  rx,
    output logic                  mem_write_flag,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [31:0]           mem_write_data,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [15:0]           words_written
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    logic                  byte_valid, frame_err;
    logic [7:0]            byte_data;
    frame_state_t          fstate_q, fstate_d;
    logic [15:0]           len_q, wcnt_q;
    logic [ADDR_WIDTH-1:0] base_q, wr_addr_q;
    logic [1:0]            bcnt_q;
    logic [23:0]           asm_q;
    logic [31:0]           wr_data_q;
    logic [7:0]            csum_q;
    logic                  done_q, error_q, wr_flag_q;
    logic                  abort, sync_acc, len_lo_wr, len_hi_wr, data_byte, word_wr;
    logic                  fin_ok, fin_bad;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i       (physical_clock),
        .rst_i       (reset),
        .en_i        (load_enable),
        .rx_i        (rx),
        .byte_valid_o(byte_valid),
        .byte_data_o (byte_data),
        .frame_err_o (frame_err)
    );

    // A line error or dropped enable closes any open frame; in F_IDLE both are don't-cares.
    assign abort = (fstate_q != F_IDLE) && (!load_enable || frame_err);

    always_ff @(posedge physical_clock) begin
        if (reset) fstate_q <= F_IDLE;
        else       fstate_q <= fstate_d;
    end

    always_comb begin
        fstate_d = fstate_q;
        if (abort) begin
            fstate_d = F_IDLE;
        end else if (byte_valid) begin
            unique case (fstate_q)
                F_IDLE:  if (byte_data == SYNC_BYTE) fstate_d = F_LEN0;
                F_LEN0:  fstate_d = F_LEN1;
                F_LEN1:  fstate_d = ({byte_data, len_q[7:0]} == 16'd0) ? F_CSUM : F_DATA;
                F_DATA:  if (bcnt_q == 2'd3 && (wcnt_q + 16'd1) == len_q) fstate_d = F_CSUM;
                F_CSUM:  fstate_d = F_IDLE;
                default: fstate_d = F_IDLE;
            endcase
        end
    end

    always_comb begin
        sync_acc  = 1'b0;
        len_lo_wr = 1'b0;
        len_hi_wr = 1'b0;
        data_byte = 1'b0;
        word_wr   = 1'b0;
        fin_ok    = 1'b0;
        fin_bad   = 1'b0;
        if (byte_valid && !abort) begin
            unique case (fstate_q)
                F_IDLE:  sync_acc = (byte_data == SYNC_BYTE);
                F_LEN0:  len_lo_wr = 1'b1;
                F_LEN1:  len_hi_wr = 1'b1;
                F_DATA: begin
                    data_byte = 1'b1;
                    word_wr   = (bcnt_q == 2'd3);
                end
                F_CSUM: begin
                    fin_ok  = (byte_data == csum_q);
                    fin_bad = (byte_data != csum_q);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge physical_clock) begin
        if (reset) begin
            len_q     <= '0;
            wcnt_q    <= '0;
            base_q    <= '0;
            bcnt_q    <= '0;
            asm_q     <= '0;
            csum_q    <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            wr_flag_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_flag_q <= word_wr;
            if (sync_acc) begin
                done_q  <= 1'b0;
                error_q <= 1'b0;
                wcnt_q  <= '0;
                csum_q  <= '0;
                bcnt_q  <= '0;
                base_q  <= base_addr;
            end
            if (len_lo_wr || len_hi_wr || data_byte) csum_q <= csum_q ^ byte_data;
            if (len_lo_wr) len_q[7:0]  <= byte_data;
            if (len_hi_wr) len_q[15:8] <= byte_data;
            // Bytes enter from the top so after three of them asm_q = {b2, b1, b0}.
            if (data_byte) begin
                bcnt_q <= bcnt_q + 2'd1;
                asm_q  <= {byte_data, asm_q[23:8]};
            end
            if (word_wr) begin
                wr_addr_q <= base_q + ADDR_WIDTH'(wcnt_q);
                wr_data_q <= {byte_data, asm_q};
                wcnt_q    <= wcnt_q + 16'd1;
            end
            if (fin_ok) done_q <= 1'b1;
            if (fin_bad || abort) error_q <= 1'b1;
        end
    end

    assign mem_write_flag = wr_flag_q;
    assign mem_write_addr = wr_addr_q;
    assign mem_write_data = wr_data_q;
    assign cpu_hold       = (fstate_q != F_IDLE);
    assign load_done      = done_q;
    assign load_error     = error_q;
    assign words_written  = wcnt_q;

endmodule

// File: doc/program_loader.md
# program_loader

Serial program/data loader: the writing end of the datapath's memory interfaces. It receives a framed byte stream on a UART line, assembles little-endian 32-bit words, and drives a single-cycle write port into instruction or data memory. While a frame is in progress it holds the CPU in its init state, so the datapath resumes from a freshly written image.

## Interface
Parameters:
- CLK_HZ, 50000000, `physical_clock` frequency.
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 434 at defaults).
- ADDR_WIDTH, 16, memory write address width.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- physical_clock  in  1  system clock; one clock domain only.
- reset  in  1  synchronous, active-high.
- load_enable  in  1  level; low means rx is ignored and any open frame is aborted.
- base_addr  in  ADDR_WIDTH  address of word 0; sampled when SYNC is accepted.
- rx  in  1  asynchronous UART line, idle high, 8N1, LSB first.
- mem_write_flag  out  1  one-cycle write strobe.
- mem_write_addr  out  ADDR_WIDTH  write address.
- mem_write_data  out  32  write data.
- cpu_hold  out  1  high while a frame is open.
- load_done  out  1  sticky; the last frame completed with a good checksum.
- load_error  out  1  sticky; framing error, checksum mismatch, or abort.
- words_written  out  16  count of words written in the current or last frame.

## Operation
- rx passes through a 2-FF synchronizer; both stages reset to 1.
- Byte receiver FSM:
  - R_IDLE: on a falling edge of the synchronized rx, go to R_START.
  - R_START: at CLKS_PER_BIT/2, if rx is low go to R_DATA; else return to R_IDLE (glitch).
  - R_DATA: sample 8 bits at CLKS_PER_BIT intervals, LSB first.
  - R_STOP: sample once more. A high stop bit raises byte_valid for 1 cycle. A low stop bit raises frame_err for 1 cycle and the byte is discarded.
  - Always returns to R_IDLE after the stop bit.
- Frame format: SYNC, LEN_LO, LEN_HI, then LEN×4 data bytes (little-endian words), then CSUM. CSUM is the XOR of every byte after SYNC, excluding CSUM itself.
- Frame FSM:
  - F_IDLE: bytes other than SYNC_BYTE are ignored. On SYNC: clear load_done, load_error, words_written and the running XOR; latch base_addr; go to F_LEN0.
  - F_LEN0 → F_LEN1: store the two length bytes.
  - F_LEN1: go to F_DATA, or straight to F_CSUM if LEN = 0.
  - F_DATA: a byte counter runs 0..3; byte k goes to data[8k+7:8k]. On byte 3, issue the write for word n at base+n, increment words_written, and move to F_CSUM after word LEN-1.
  - F_CSUM: a match sets load_done; a mismatch sets load_error; both go to F_IDLE.
- frame_err in any state other than F_IDLE sets load_error and forces F_IDLE. frame_err in F_IDLE is ignored.
- load_enable low in any state other than F_IDLE sets load_error and forces F_IDLE. The byte receiver is also held in R_IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH: base+n wraps without error.
- Words already written before an error remain in memory; nothing is rolled back.

## Timing
- Reset values:
  - all outputs 0, cpu_hold 0;
  - both FSMs in their idle state;
  - synchronizer 1, all counters 0.
- byte_valid fires 2 synchronizer cycles plus about 9.5 bit times after the start-bit edge.
- mem_write_flag is registered and high exactly 1 cycle, the cycle after byte_valid for byte 3. Address and data are stable in that cycle and hold until the next write.
- cpu_hold:
  - rises the cycle after SYNC byte_valid;
  - falls the cycle after the CSUM byte_valid, or the cycle after an abort or error;
  - load_done and load_error update in the same cycle it falls.
- No back-pressure: memory must accept a write every cycle the strobe is high. Writes are at least 40 bit times apart.
- A SYNC byte received inside a frame is treated as data, not a restart.
- reset mid-frame: next cycle all state returns to reset values and no strobe is issued.

## Structure
- Shared package holds:
  - SYNC_BYTE default;
  - byte FSM state encodings R_IDLE/R_START/R_DATA/R_STOP;
  - frame FSM encodings F_IDLE/F_LEN0/F_LEN1/F_DATA/F_CSUM.
- One sub-module, uart_rx_byte (synchronizer, baud counter, byte FSM). Its outputs are byte_valid, byte_data[7:0] and frame_err.
- The top level contains the frame FSM, word assembler, address counter and status flags.

## Test plan
- Valid 2-word load: base 16'h0100; bytes A5 02 00 78 56 34 12 EF BE AD DE, then the correct XOR. Required:
  - writes 12345678→0100 and DEADBEEF→0101, each strobe 1 cycle wide;
  - load_done=1, words_written=2, cpu_hold low after CSUM.
- Bad checksum: same frame with CSUM^8'h01 → both writes occur, load_error=1, load_done=0.
- LEN=0: A5 00 00 00 → no strobe, load_done=1.
- Noise and glitches:
  - bytes 00 FF 3C before SYNC are ignored, cpu_hold stays 0;
  - a 100-cycle low pulse on rx produces no byte.
- Framing and abort:
  - stop bit driven low during a data byte → load_error=1, cpu_hold drops;
  - load_enable dropped mid-frame → same response.
- Wrap-around and reset:
  - base 16'hFFFF, LEN=2 → writes land at FFFF then 0000;
  - reset asserted after word 0 → all outputs 0 next cycle, no further strobes.
